// File: rtl/mont_ctrl_pkg.sv
// Shared definitions for the Montgomery adder sequencer: state encoding,
// operand-select codes and the mpadder phase code used while idle.
package mont_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAdd,
    StShift,
    StResolve,
    StSub,
    StDone
  } state_e;

  // Operand mux select driven towards the external zero/B/M/-M mux
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_M    = 2'b10;
  localparam logic [1:0] SEL_NEGM = 2'b11;

  // Phase code that freezes mpadder's carry_in register
  localparam logic [3:0] PHASE_IDLE = 4'd8;

  localparam int unsigned N_CHUNK = 5;

endpackage

// File: rtl/mont_phase_cnt.sv
// Carry-propagate phase counter: counts 0..N_CHUNK-1 and wraps, with a
// synchronous clear and a terminal-count flag. Shared by resolve and subtract.
module mont_phase_cnt #(
  parameter int unsigned N_CHUNK = 5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] phase,
  output logic       tc
);

  assign tc = (phase == 4'(N_CHUNK - 1));

  // Advance one chunk per enabled cycle, wrapping at terminal count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase <= 4'd0;
    end else if (clr) begin
      phase <= 4'd0;
    end else if (en) begin
      phase <= tc ? 4'd0 : phase + 4'd1;
    end
  end

endmodule

// File: rtl/mont_adder_ctrl.sv
// Sequencer for one 512-bit Montgomery product on mpadder: bit-serial
// add/shift over A, chunked carry propagation, then conditional subtract
// passes. Optional build macro MONT_CTRL_ZERO_SKIP_EN skips the add slot
// for zero bits of A (data-dependent timing; off by default).
module mont_adder_ctrl
  import mont_ctrl_pkg::*;
#(
  parameter int unsigned N_BITS  = 512,
  parameter int unsigned N_CHUNK = mont_ctrl_pkg::N_CHUNK,
  parameter int unsigned MAX_SUB = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [N_BITS-1:0] a_op,
  output logic              busy,
  output logic              done,
  output logic [1:0]        add_sel,
  output logic              add_enable_c,
  output logic              add_shift,
  output logic [3:0]        add_phase,
  output logic              add_subtract,
  input  logic              add_czero,
  input  logic              add_sub_done
);

  localparam int unsigned IterW = $clog2(N_BITS);
  localparam int unsigned SubW  = (MAX_SUB > 1) ? $clog2(MAX_SUB) : 1;

  state_e            state_q;
  logic [N_BITS-1:0] a_sh_q;
  logic [IterW-1:0]  iter_q;
  logic [SubW-1:0]   sub_cnt_q;
  logic [3:0]        phase;
  logic              phase_tc;
  logic              phase_clr;

  assign phase_clr = (state_q != StResolve) && (state_q != StSub);

  mont_phase_cnt #(
    .N_CHUNK(N_CHUNK)
  ) u_phase_cnt (
    .clk   (clk),
    .resetn(resetn),
    .clr   (phase_clr),
    .en    (1'b1),
    .phase (phase),
    .tc    (phase_tc)
  );

  // Sequencer FSM with iteration counter, A shift register and pass counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      iter_q    <= '0;
      sub_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sub_cnt_q <= '0;
          if (start) begin
            a_sh_q <= a_op;
            iter_q <= '0;
`ifdef MONT_CTRL_ZERO_SKIP_EN
            state_q <= a_op[0] ? StAdd : StShift;
`else
            state_q <= StAdd;
`endif
          end
        end
        StAdd: begin
          state_q <= StShift;
        end
        StShift: begin
          a_sh_q <= a_sh_q >> 1;
          iter_q <= iter_q + 1'b1;
          // Compare happens before the counter wraps past N_BITS-1
          if (iter_q == IterW'(N_BITS - 1)) begin
            state_q <= StResolve;
          end else begin
`ifdef MONT_CTRL_ZERO_SKIP_EN
            state_q <= a_sh_q[1] ? StAdd : StShift;
`else
            state_q <= StAdd;
`endif
          end
        end
        StResolve: begin
          if (phase_tc) begin
            state_q <= StSub;
          end
        end
        StSub: begin
          if (phase_tc) begin
            if (add_sub_done || (sub_cnt_q == SubW'(MAX_SUB - 1))) begin
              state_q <= StDone;
            end else begin
              sub_cnt_q <= sub_cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Moore decode of outputs; only SHIFT's select looks at add_czero
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    add_sel      = SEL_ZERO;
    add_enable_c = 1'b0;
    add_shift    = 1'b0;
    add_phase    = PHASE_IDLE;
    add_subtract = 1'b0;
    unique case (state_q)
      StIdle: ;
      StAdd: begin
        busy         = 1'b1;
        add_enable_c = 1'b1;
        add_sel      = a_sh_q[0] ? SEL_B : SEL_ZERO;
      end
      StShift: begin
        busy      = 1'b1;
        add_shift = 1'b1;
        add_sel   = add_czero ? SEL_M : SEL_ZERO;
      end
      StResolve: begin
        busy      = 1'b1;
        add_phase = phase;
      end
      StSub: begin
        busy         = 1'b1;
        add_subtract = 1'b1;
        add_sel      = SEL_NEGM;
        add_phase    = phase;
      end
      StDone: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
